bram_req_adapter: RTL and testbench



---
 rtl/bram_req_adapter.sv | 119 +++++++++++
 tb/tb_bram_req_adapter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_req_adapter.sv
// Valid/ready request front-end for one BRAM port with read-latency tracking and a response FIFO.
// Optional macro BRAM_ADAPTER_BYPASS_EN: returned read data is presented in its arrival cycle when the FIFO is empty.
module bram_req_adapter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int WE_WIDTH   = 4,
    parameter int PIPELINED  = 0,
    parameter int RESP_DEPTH = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WE_WIDTH-1:0]   req_be,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  bram_en,
    output logic [WE_WIDTH-1:0]   bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_di,
    input  logic [DATA_WIDTH-1:0] bram_do
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
    // ready never depends combinationally on the matching valid or on resp_ready.
    localparam int LAT   = 1 + PIPELINED;
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + LAT + 1);

    logic [LAT-1:0]        rd_pipe;
    logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      inflight;
    logic [CNT_W-1:0]      outstanding;
    logic                  fire;
    logic                  rd_fire;
    logic                  arrive;
    logic                  fifo_empty;
    logic                  bypass_take;
    logic                  enq;
    logic                  deq;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CNT_W'(rd_pipe[i]);
        end
    end

    // A read holds its credit from acceptance until its response is taken.
    assign outstanding = fifo_count + inflight;
    assign req_ready   = !RST && (outstanding < CNT_W'(RESP_DEPTH));
    assign fire        = req_valid && req_ready;
    assign rd_fire     = fire && !req_write;

    assign bram_en   = fire;
    assign bram_addr = req_addr;
    assign bram_di   = req_data;
    assign bram_we   = (fire && req_write) ? req_be : '0;

    assign arrive     = rd_pipe[LAT-1];
    assign fifo_empty = (fifo_count == '0);

`ifdef BRAM_ADAPTER_BYPASS_EN
    assign bypass_take = arrive && fifo_empty && resp_ready;
    assign resp_valid  = !fifo_empty || arrive;
    assign resp_data   = fifo_empty ? bram_do : fifo_mem[rd_ptr];
`else
    assign bypass_take = 1'b0;
    assign resp_valid  = !fifo_empty;
    assign resp_data   = fifo_mem[rd_ptr];
`endif

    assign enq = arrive && !bypass_take;
    assign deq = !fifo_empty && resp_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_pipe    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            rd_pipe[0] <= rd_fire;
            for (int i = 1; i < LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            if (enq) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (deq) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            // Simultaneous enqueue and dequeue leaves the count unchanged, even when full.
            case ({enq, deq})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && enq) begin
            fifo_mem[wr_ptr] <= bram_do;
        end
    end

endmodule

// File: tb/tb_bram_req_adapter.sv
// Bench for bram_req_adapter: two instances (PIPELINED=0/DEPTH=2 and PIPELINED=1/DEPTH=3), each with a BRAM model.
// Honours BRAM_ADAPTER_BYPASS_EN for expected read latency.
module tb_bram_req_adapter;

`ifdef BRAM_ADAPTER_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    // ---------------- clock / reset / shared stimulus ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_init;
    int          sel;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_data;
    logic        resp_ready;

    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [15:0] bram_addr;
    logic [31:0] bram_di;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [15:0] a);
        case (a)
            16'h0004: return 32'hAAAAAAAA;
            16'h0010: return 32'hDEADBEEF;
            16'h0020: return 32'h0BADF00D;
            default:  return {a ^ 16'h5A5A, ~a};
        endcase
    endfunction

    // ---------------- DUTs and BRAM models ----------------
    for (genvar g = 0; g < 2; g++) begin : gen_dut
        logic        rdy;
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        en;
        logic [3:0]  we;
        logic [15:0] addr;
        logic [31:0] di;
        logic [31:0] dout;
        logic [31:0] do_q;
        logic [31:0] do_q2;
        logic [31:0] bmem [65536];

        bram_req_adapter #(
            .ADDR_WIDTH(16),
            .DATA_WIDTH(32),
            .WE_WIDTH(4),
            .PIPELINED(g),
            .RESP_DEPTH((g == 0) ? 2 : 3)
        ) u_dut (
            .CLK       (clk),
            .RST       (rst),
            .req_valid (req_valid && (sel == g)),
            .req_ready (rdy),
            .req_write (req_write),
            .req_addr  (req_addr),
            .req_be    (req_be),
            .req_data  (req_data),
            .resp_valid(rsp_v),
            .resp_ready(resp_ready && (sel == g)),
            .resp_data (rsp_d),
            .bram_en   (en),
            .bram_we   (we),
            .bram_addr (addr),
            .bram_di   (di),
            .bram_do   (dout)
        );

        always @(posedge clk) begin
            if (mem_init) begin
                for (int i = 0; i < 65536; i++) bmem[i] <= init_word(16'(i));
            end else if (en) begin
                do_q <= bmem[addr];
                for (int b = 0; b < 4; b++) begin
                    if (we[b]) bmem[addr][8*b +: 8] <= di[8*b +: 8];
                end
            end
            do_q2 <= do_q;
        end
        assign dout = (g == 1) ? do_q2 : do_q;
    end

    assign req_ready  = (sel == 1) ? gen_dut[1].rdy   : gen_dut[0].rdy;
    assign resp_valid = (sel == 1) ? gen_dut[1].rsp_v : gen_dut[0].rsp_v;
    assign resp_data  = (sel == 1) ? gen_dut[1].rsp_d : gen_dut[0].rsp_d;
    assign bram_en    = (sel == 1) ? gen_dut[1].en    : gen_dut[0].en;
    assign bram_we    = (sel == 1) ? gen_dut[1].we    : gen_dut[0].we;
    assign bram_addr  = (sel == 1) ? gen_dut[1].addr  : gen_dut[0].addr;
    assign bram_di    = (sel == 1) ? gen_dut[1].di    : gen_dut[0].di;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model and scoreboard ----------------
    // Outstanding reads = accepted reads minus taken responses; expected read data
    // is the model memory word at acceptance time, returned in order.
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [65536];
    int          n_rd_acc;
    int          n_consumed;
    int          depth;
    logic        exp_ready;
    logic        exp_fire;

    always @(negedge clk) begin
        depth     = (sel == 1) ? 3 : 2;
        exp_ready = !rst && ((n_rd_acc - n_consumed) < depth);
        exp_fire  = req_valid && exp_ready;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("bram_en", 32'(bram_en), 32'(exp_fire));
        check("bram_we", 32'(bram_we), 32'((exp_fire && req_write) ? req_be : 4'b0000));
        if (exp_fire) begin
            check("bram_addr", 32'(bram_addr), 32'(req_addr));
            check("bram_di", bram_di, req_data);
        end
        if (exp_q.size() == 0) check("resp_idle", 32'(resp_valid), 32'(1'b0));
        if (rst) begin
            exp_q.delete();
            n_rd_acc   = 0;
            n_consumed = 0;
            if (mem_init) begin
                for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(16'(i));
            end
        end else begin
            if (resp_valid && resp_ready && exp_q.size() != 0) begin
                check("resp_data", resp_data, exp_q.pop_front());
                n_consumed++;
            end
            if (exp_fire) begin
                if (req_write) begin
                    for (int b = 0; b < 4; b++) begin
                        if (req_be[b]) ref_mem[req_addr][8*b +: 8] = req_data[8*b +: 8];
                    end
                end else begin
                    exp_q.push_back(ref_mem[req_addr]);
                    n_rd_acc++;
                end
            end
        end
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic do_reset(input logic init, input int cycles);
        rst      = 1'b1;
        mem_init = init;
        repeat (cycles) @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_init = 1'b0;
    endtask

    task automatic wait_accept(output int waited);
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("accept_timeout", 32'(req_ready), 32'(1'b1));
    endtask

    task automatic send(input logic w, input logic [15:0] a, input logic [3:0] be,
                        input logic [31:0] d, output int waited);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_be    = be;
        req_data  = d;
        wait_accept(waited);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic read_lat(input logic [15:0] a, input int exp_lat, input string tag,
                            output logic [31:0] got);
        int   w;
        int   n;
        logic seen;
        send(1'b0, a, 4'($urandom), $urandom, w);
        n    = 1;
        seen = 1'b0;
        got  = 'x;
        @(negedge clk);
        if (resp_valid) begin seen = 1'b1; got = resp_data; end
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (resp_valid) begin seen = 1'b1; got = resp_data; end
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        resp_ready = 1'b1;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic rand_run(input int n);
        logic took = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!req_valid || took) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_write = ($urandom_range(0, 2) == 0);
                req_addr  = 16'($urandom_range(0, 15));
                req_be    = 4'($urandom);
                req_data  = $urandom;
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = req_valid && req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] d;
        int          w;
        int          total;
        int          acc;
        rst = 1'b1; mem_init = 1'b1; sel = 0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_be = '0; req_data = '0;
        resp_ready = 1'b1;
        n_rd_acc = 0; n_consumed = 0;

        // PIPELINED=0, RESP_DEPTH=2
        do_reset(1'b1, 2);
        @(negedge clk);
        check("post_reset_ready", 32'(req_ready), 32'(1'b1));
        check("post_reset_resp_valid", 32'(resp_valid), 32'(1'b0));
        @(posedge clk);
        #1;

        read_lat(16'h0010, 2 - BYP, "rd_0010", d);
        check("rd_0010_data", d, 32'hDEADBEEF);

        send(1'b1, 16'h0004, 4'b0011, 32'h12345678, w);
        read_lat(16'h0004, 2 - BYP, "rd_0004", d);
        check("rd_0004_data", d, 32'hAAAA5678);

        total = 0;
        for (int i = 0; i < 10; i++) begin
            send(1'b0, 16'(i), 4'hF, $urandom, w);
            total += w + 1;
        end
        check("b2b_rate_ok", 32'(total <= 20), 32'(1'b1));
        drain();

        resp_ready = 1'b0;
        acc = 0;
        req_write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_valid = (acc < 4);
            req_addr  = 16'h0030 + 16'(acc);
            req_data  = $urandom;
            @(negedge clk);
            if (req_valid && req_ready) acc++;
            @(posedge clk);
            #1;
        end
        check("bp_accepted", 32'(acc), 32'(2));
        @(negedge clk);
        check("bp_ready_low", 32'(req_ready), 32'(1'b0));
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_still_held", 32'(req_ready), 32'(1'b0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_credit_back", 32'(req_ready), 32'(1'b1));
        @(posedge clk);
        #1;
        send(1'b0, 16'h0033, 4'hF, $urandom, w);
        drain();

        rand_run(400);
        drain();

        // PIPELINED=1, RESP_DEPTH=3
        sel = 1;
        do_reset(1'b1, 2);
        read_lat(16'h0020, 3 - BYP, "rd_0020", d);
        check("rd_0020_data", d, 32'h0BADF00D);

        resp_ready = 1'b0;
        send(1'b0, 16'h0040, 4'hF, $urandom, w);
        send(1'b0, 16'h0041, 4'hF, $urandom, w);
        send(1'b0, 16'h0042, 4'hF, $urandom, w);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0040; req_be = 4'hF; req_data = 32'hFFFFFFFF;
        do_reset(1'b0, 1);
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_reset_resp_valid", 32'(resp_valid), 32'(1'b0));
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        read_lat(16'h0040, 3 - BYP, "rd_after_reset", d);
        check("rd_after_reset_data", d, init_word(16'h0040));

        rand_run(400);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
